// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding, sizes and byte-lane constants for the imem loader
// Optional checksum trailer is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int DEPTH_DEF  = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W      = 6;
    localparam int LANE_W     = 8;
    localparam int LANES      = 4;
    localparam int WORD_W     = LANE_W * LANES;

    // Index of the final byte of a word; byte 0 lands in the most significant lane.
    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] req, input int depth);
        return (int'(req) > depth) ? CNT_W'(depth) : req;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - control, byte stream and memory-write bundle of the imem loader
// slave is the loader side, master is the environment driving it.
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic [5:0]        word_count;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport slave (
        input  start, word_count, rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );

    modport master (
        output start, word_count, rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - packs four stream bytes into a big-endian word
// word_ready_o marks the edge that takes the 4th byte; word_o is the completed word then.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [LANE_W-1:0] byte_i,
    output logic              word_ready_o,
    output logic [WORD_W-1:0] word_o
);

    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;

    assign word_o       = {shift_q[WORD_W-LANE_W-1:0], byte_i};
    assign word_ready_o = byte_valid_i && (cnt_q == LAST_LANE);

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = word_o;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader for the 32-word instruction memory, holds the CPU while loading
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 32-bit sum word and report mismatches on error.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic         clk_i,
    input  logic         reset_i,
    imem_loader_if.slave bus
);

    state_e            state_q;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              rx_ready_q;
    logic              we_q;
    logic              hold_q;
    logic              done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic              error_q;
    logic [WORD_W-1:0] sum_q;
`endif

    logic              start_ok;
    logic              byte_ok;
    logic              word_ready;
    logic [WORD_W-1:0] word;
    logic [CNT_W-1:0]  req_count;
    logic              last_word;

    assign start_ok  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign byte_ok   = bus.rx_valid && rx_ready_q;
    assign req_count = clamp_count(bus.word_count, DEPTH);
    assign last_word = (CNT_W'(addr_q) == (count_q - CNT_W'(1)));

    byte_assembler u_asm (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (start_ok),
        .byte_valid_i (byte_ok),
        .byte_i       (bus.rx_data),
        .word_ready_o (word_ready),
        .word_o       (word)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            error_q    <= 1'b0;
            sum_q      <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        count_q <= req_count;
                        addr_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        error_q <= 1'b0;
                        sum_q   <= '0;
`endif
                        if (req_count == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q    <= ST_RECV;
                            done_q     <= 1'b0;
                            hold_q     <= 1'b1;
                            rx_ready_q <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (word_ready) begin
                        wdata_q    <= word;
                        we_q       <= 1'b1;
                        rx_ready_q <= 1'b0;
                        state_q    <= ST_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q      <= sum_q + word;
`endif
                    end
                end
                ST_WRITE: begin
                    we_q <= 1'b0;
                    // The address stops at the last word so a full-depth load never wraps to 0.
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q    <= ST_CHECK;
                        rx_ready_q <= 1'b1;
`else
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        hold_q     <= 1'b0;
`endif
                    end else begin
                        addr_q     <= addr_q + ADDR_W'(1);
                        state_q    <= ST_RECV;
                        rx_ready_q <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (word_ready) begin
                        error_q    <= (word != sum_q);
                        done_q     <= 1'b1;
                        hold_q     <= 1'b0;
                        rx_ready_q <= 1'b0;
                        state_q    <= ST_DONE;
                    end
                end
`endif
                default: begin
                    state_q    <= ST_IDLE;
                    rx_ready_q <= 1'b0;
                    we_q       <= 1'b0;
                    hold_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.done       = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.error      = error_q;
`else
    assign bus.error      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader (also covers IMEM_LOADER_CHECKSUM_EN builds)
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(5)) bus ();

    imem_loader dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [4:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] words[0:39];

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [5:0] c);
        bus.word_count = c;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit got;
        got = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
                tick();
            end
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.rx_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            tick();
        end else begin
            $display("FAIL byte_accept_timeout: byte %h never accepted, rx_ready=%b required 1", b, bus.rx_ready);
            total_cnt++;
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        send_byte(w[31:24], gaps);
        send_byte(w[23:16], gaps);
        send_byte(w[15:8],  gaps);
        send_byte(w[7:0],   gaps);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) $display("FAIL done_timeout: done=%b required 1", bus.done);
        else pass_cnt++;
        total_cnt++;
    endtask

    // Loads n words from words[], requesting req words; optionally pokes start while busy.
    task automatic run_load(input string name, input logic [5:0] req, input int n,
                            input bit gaps, input bit bad_sum, input bit poke_start);
        logic [31:0] sum;
        logic        exp_err;
        sum = 32'h0;
        wr_addr.delete();
        wr_data.delete();
        do_start(req);
        if (bus.cpu_hold !== 1'b1) $display("FAIL %s_hold_busy: cpu_hold=%b required 1", name, bus.cpu_hold);
        else pass_cnt++;
        total_cnt++;
        for (int i = 0; i < n; i++) begin
            send_word(words[i], gaps);
            sum = sum + words[i];
            if ({bus.imem_we, bus.rx_ready} !== 2'b10)
                $display("FAIL %s_we_timing[%0d]: we,rx_ready=%b required 10", name, i, {bus.imem_we, bus.rx_ready});
            else pass_cnt++;
            total_cnt++;
            if (poke_start && i == 0) begin
                bus.word_count = 6'd1;
                bus.start      = 1'b1;
                tick();
                tick();
                bus.start      = 1'b0;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(sum + {31'h0, bad_sum}, gaps);
        exp_err = bad_sum;
`else
        exp_err = bad_sum & 1'b0;
`endif
        wait_done();
        tick();
        if (wr_data.size() !== n) $display("FAIL %s_write_count: got %0d required %0d", name, wr_data.size(), n);
        else pass_cnt++;
        total_cnt++;
        for (int i = 0; i < n && i < wr_data.size(); i++) begin
            if ({wr_addr[i], wr_data[i]} !== {5'(i), words[i]})
                $display("FAIL %s_write[%0d]: got addr %0d data %h required addr %0d data %h",
                         name, i, wr_addr[i], wr_data[i], i, words[i]);
            else pass_cnt++;
            total_cnt++;
        end
        if ({bus.done, bus.cpu_hold, bus.error, bus.rx_ready} !== {1'b1, 1'b0, exp_err, 1'b0})
            $display("FAIL %s_end_state: done,hold,error,rx_ready=%b required %b", name,
                     {bus.done, bus.cpu_hold, bus.error, bus.rx_ready}, {1'b1, 1'b0, exp_err, 1'b0});
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.word_count = 6'd0;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        repeat (3) tick();
        if ({bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_hold, bus.done, bus.error} !== 42'h0)
            $display("FAIL reset_outputs: got %h required 0",
                     {bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_hold, bus.done, bus.error});
        else pass_cnt++;
        total_cnt++;
        rst = 1'b0;
        tick();
        do_start(6'd1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst = 1'b1;
        #1;
        if ({bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_hold, bus.done, bus.error} !== 42'h0)
            $display("FAIL reset_mid_load: got %h required 0",
                     {bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_hold, bus.done, bus.error});
        else pass_cnt++;
        total_cnt++;
        tick();
        rst = 1'b0;
        tick();
        words[0] = 32'h11223344;
        run_load("after_reset", 6'd1, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_two_words();
        words[0] = 32'h20080005;
        words[1] = 32'h8C090000;
        run_load("two_words", 6'd2, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random_valid();
        words[0] = 32'hDEADBEEF;
        words[1] = 32'h01234567;
        words[2] = 32'hA5C3F00F;
        run_load("random_valid", 6'd3, 3, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 40; i++) begin
            words[i] = {8'(i), ~8'(i), 8'h5A, 8'(i * 3)};
        end
        run_load("clamp40", 6'd40, 32, 1'b0, 1'b0, 1'b0);
        if (wr_addr.size() == 32 && wr_addr[31] !== 5'd31)
            $display("FAIL clamp_last_addr: got %0d required 31", wr_addr[31]);
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_start_ignored();
        words[0] = 32'hCAFEF00D;
        words[1] = 32'h13579BDF;
        run_load("start_ignored", 6'd2, 2, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_zero_count();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        wr_addr.delete();
        wr_data.delete();
        do_start(6'd0);
        if ({bus.done, bus.cpu_hold, bus.rx_ready} !== 3'b100)
            $display("FAIL zero_count_done: done,hold,rx_ready=%b required 100", {bus.done, bus.cpu_hold, bus.rx_ready});
        else pass_cnt++;
        total_cnt++;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h77;
        repeat (4) tick();
        bus.rx_valid = 1'b0;
        if (wr_data.size() !== 0) $display("FAIL zero_count_writes: got %0d required 0", wr_data.size());
        else pass_cnt++;
        total_cnt++;
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        words[0] = 32'h00000001;
        run_load("checksum_good", 6'd1, 1, 1'b0, 1'b0, 1'b0);
        run_load("checksum_bad", 6'd1, 1, 1'b0, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_two_words();
        test_random_valid();
        test_clamp();
        test_start_ignored();
        test_zero_count();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
